// File: rtl/dmem_unit.sv
// Data memory unit: byte-addressed 32-bit word RAM with B/H/W loads and stores,
// one-cycle load latency, fault reporting and saturating access counters.
module dmem_unit #(
    parameter int DATA_W  = 32,
    parameter int DEPTH_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [8:0]        addr,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              stall,
    output logic              done,
    output logic              fault,
    output logic [15:0]       ld_cnt,
    output logic [15:0]       st_cnt
);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t state;

    logic [31:0] mem [2**DEPTH_W];

    logic [DEPTH_W-1:0] widx;
    logic [31:0]        word;
    logic [7:0]         byte_v;
    logic [15:0]        half_v;
    logic [3:0]         be;
    logic [31:0]        wdat;
    logic [DATA_W-1:0]  ld_val;
    logic               legal;
    logic               idle;
    logic               req;
    logic               do_st;
    logic               do_ld;
    logic               flt;

    assign widx   = addr[DEPTH_W+1:2];
    assign word   = mem[widx];
    assign byte_v = word[{addr[1:0], 3'b000} +: 8];
    assign half_v = word[{addr[1], 4'b0000} +: 16];

    // BU/HU only exist as loads; a store with those encodings is illegal
    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = !addr[0];
            3'b010:  legal = (addr[1:0] == 2'b00);
            3'b100:  legal = !wr;
            3'b101:  legal = !wr && !addr[0];
            default: legal = 1'b0;
        endcase
    end

    assign idle  = (state == IDLE) && reset;
    assign req   = idle && (wr || rd);
    assign do_st = idle && wr && legal;
    assign do_ld = idle && rd && !wr && legal;
    assign flt   = req && (!legal || (wr && rd));
    assign stall = do_ld;

    always_comb begin
        be   = 4'h0;
        wdat = {4{wr_data[7:0]}};
        case (funct3[1:0])
            2'b00: be = 4'b0001 << addr[1:0];
            2'b01: begin
                be   = addr[1] ? 4'b1100 : 4'b0011;
                wdat = {2{wr_data[15:0]}};
            end
            default: begin
                be   = 4'hF;
                wdat = wr_data[31:0];
            end
        endcase
    end

    always_comb begin
        ld_val = DATA_W'(word);
        case (funct3)
            3'b000:  ld_val = DATA_W'($signed(byte_v));
            3'b100:  ld_val = DATA_W'(byte_v);
            3'b001:  ld_val = DATA_W'($signed(half_v));
            3'b101:  ld_val = DATA_W'(half_v);
            default: ld_val = DATA_W'(word);
        endcase
    end

    // No reset on the array: contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (do_st) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][i*8 +: 8] <= wdat[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            rd_data <= '0;
            done    <= 1'b0;
            fault   <= 1'b0;
            ld_cnt  <= 16'h0000;
            st_cnt  <= 16'h0000;
        end else begin
            done  <= req;
            fault <= flt;
            case (state)
                IDLE: begin
                    if (do_ld) begin
                        state   <= LOAD;
                        rd_data <= ld_val;
                        if (ld_cnt != 16'hFFFF) ld_cnt <= ld_cnt + 16'h1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (do_st && st_cnt != 16'hFFFF) st_cnt <= st_cnt + 16'h1;
        end
    end

endmodule

// File: tb/tb_dmem_unit.sv
// Directed self-checking bench for dmem_unit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dmem_unit;

    logic        clk;
    logic        reset;
    logic        wr;
    logic        rd;
    logic [8:0]  addr;
    logic [2:0]  funct3;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        stall;
    logic        done;
    logic        fault;
    logic [15:0] ld_cnt;
    logic [15:0] st_cnt;

    int n_chk;
    int n_fail;

    dmem_unit dut (
        .clk     (clk),
        .reset   (reset),
        .wr      (wr),
        .rd      (rd),
        .addr    (addr),
        .funct3  (funct3),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .stall   (stall),
        .done    (done),
        .fault   (fault),
        .ld_cnt  (ld_cnt),
        .st_cnt  (st_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic do_store(input logic [8:0] a, input logic [2:0] f,
                            input logic [31:0] d);
        wr = 1'b1; rd = 1'b0; addr = a; funct3 = f; wr_data = d;
        #1 check("st_stall", stall, 1'b0);
        @(negedge clk);
        check("st_done", done, 1'b1);
        check("st_fault", fault, 1'b0);
        idle_in();
    endtask

    task automatic do_load(input logic [8:0] a, input logic [2:0] f,
                           input logic [31:0] exp);
        wr = 1'b0; rd = 1'b1; addr = a; funct3 = f;
        #1 check("ld_stall_acc", stall, 1'b1);
        @(negedge clk);
        check("ld_stall_load", stall, 1'b0);
        check("ld_done", done, 1'b1);
        check("ld_fault", fault, 1'b0);
        check("ld_data", rd_data, exp);
        idle_in();
        @(negedge clk);
    endtask

    task automatic do_fault(input logic w, input logic r, input logic [8:0] a,
                            input logic [2:0] f, input logic [31:0] d,
                            input logic [31:0] keep);
        wr = w; rd = r; addr = a; funct3 = f; wr_data = d;
        #1 check("flt_stall", stall, 1'b0);
        @(negedge clk);
        check("flt_fault", fault, 1'b1);
        check("flt_done", done, 1'b1);
        check("flt_rdata", rd_data, keep);
        idle_in();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b0;
        addr = '0; funct3 = '0; wr_data = '0;
        idle_in();
        repeat (2) @(negedge clk);
        check("rst_rdata", rd_data, 32'h0);
        check("rst_done", done, 1'b0);
        check("rst_fault", fault, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_ldcnt", ld_cnt, 16'h0);
        check("rst_stcnt", st_cnt, 16'h0);
        reset = 1'b1;

        // SW then LW
        do_store(9'h010, 3'b010, 32'hDEADBEEF);
        check("sw_stcnt", st_cnt, 16'd1);
        do_load(9'h010, 3'b010, 32'hDEADBEEF);
        check("lw_ldcnt", ld_cnt, 16'd1);
        check("idle_done", done, 1'b0);

        // Byte store, sign/zero extended byte loads
        do_store(9'h013, 3'b000, 32'hAAAAAA80);
        do_load(9'h013, 3'b000, 32'hFFFFFF80);
        do_load(9'h013, 3'b100, 32'h00000080);
        do_load(9'h010, 3'b010, 32'h80ADBEEF);

        // Upper half store, halfword loads
        do_store(9'h016, 3'b001, 32'h1234CAFE);
        do_load(9'h016, 3'b001, 32'hFFFFCAFE);
        do_load(9'h016, 3'b101, 32'h0000CAFE);
        check("h_ldcnt", ld_cnt, 16'd6);
        check("h_stcnt", st_cnt, 16'd3);

        // Misaligned and illegal accesses
        do_fault(1'b0, 1'b1, 9'h011, 3'b001, 32'h0, 32'h0000CAFE);
        do_fault(1'b0, 1'b1, 9'h012, 3'b010, 32'h0, 32'h0000CAFE);
        do_fault(1'b0, 1'b1, 9'h010, 3'b011, 32'h0, 32'h0000CAFE);
        do_fault(1'b1, 1'b0, 9'h010, 3'b100, 32'h11, 32'h0000CAFE);
        do_fault(1'b1, 1'b0, 9'h011, 3'b010, 32'h11223344, 32'h0000CAFE);
        check("flt_ldcnt", ld_cnt, 16'd6);
        check("flt_stcnt", st_cnt, 16'd3);
        do_load(9'h010, 3'b010, 32'h80ADBEEF);

        // wr and rd together: store wins, fault pulses
        do_fault(1'b1, 1'b1, 9'h020, 3'b010, 32'h12345678, 32'h80ADBEEF);
        do_load(9'h020, 3'b010, 32'h12345678);
        check("wrrd_ldcnt", ld_cnt, 16'd8);

        // Back-to-back loads: stall 1,0,1,0
        rd = 1'b1; addr = 9'h010; funct3 = 3'b010;
        #1 check("b2b_stall0", stall, 1'b1);
        @(negedge clk);
        check("b2b_stall1", stall, 1'b0);
        check("b2b_data1", rd_data, 32'h80ADBEEF);
        addr = 9'h020;
        @(negedge clk);
        check("b2b_stall2", stall, 1'b1);
        check("b2b_done2", done, 1'b0);
        @(negedge clk);
        check("b2b_stall3", stall, 1'b0);
        check("b2b_done3", done, 1'b1);
        check("b2b_data3", rd_data, 32'h12345678);
        check("b2b_ldcnt", ld_cnt, 16'd10);
        idle_in();
        @(negedge clk);

        // Reset during LOAD aborts, memory survives
        rd = 1'b1; addr = 9'h010; funct3 = 3'b010;
        @(negedge clk);
        reset = 1'b0;
        idle_in();
        #1;
        check("abort_done", done, 1'b0);
        check("abort_rdata", rd_data, 32'h0);
        check("abort_stall", stall, 1'b0);
        check("abort_ldcnt", ld_cnt, 16'h0);
        @(negedge clk);
        reset = 1'b1;
        do_load(9'h020, 3'b010, 32'h12345678);
        do_load(9'h013, 3'b100, 32'h00000080);
        check("post_ldcnt", ld_cnt, 16'd2);

        // Store counter saturation
        check("sat_start", st_cnt, 16'h0);
        wr = 1'b1; addr = 9'h040; funct3 = 3'b010; wr_data = 32'hCAFEF00D;
        repeat (65534) @(negedge clk);
        idle_in();
        check("sat_fffe", st_cnt, 16'hFFFE);
        do_store(9'h044, 3'b010, 32'h1);
        check("sat_ffff", st_cnt, 16'hFFFF);
        do_store(9'h048, 3'b010, 32'h2);
        do_store(9'h04C, 3'b010, 32'h3);
        check("sat_hold", st_cnt, 16'hFFFF);
        do_load(9'h04C, 3'b010, 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
